// File: rtl/ysyx_22040750_axi_mem_slave_pkg.sv
// Shared types and constants for the AXI memory slave and its storage array.
package ysyx_22040750_axi_mem_slave_pkg;

    localparam int unsigned BEAT_W = 64;
    localparam int unsigned STRB_W = BEAT_W / 8;
    localparam int unsigned RESP_W = 2;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_RESP
    } state_e;

    // One write beat as presented to the storage array.
    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

    function automatic logic [RESP_W-1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22040750_mem_array.sv
// Word-addressed storage: synchronous byte-masked write, combinational read.
module ysyx_22040750_mem_array
    import ysyx_22040750_axi_mem_slave_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  wbeat_t            wbeat,
    input  logic [IDX_W-1:0]  raddr,
    output logic [BEAT_W-1:0] rdata_c
);

    logic [BEAT_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(STRB_W); k++) begin
                if (wbeat.strb[k]) begin
                    mem_q[waddr][k*8 +: 8] <= wbeat.data[k*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/ysyx_22040750_axi_mem_slave.sv
// Single-outstanding AXI burst memory slave with fixed read latency and range checking.
module ysyx_22040750_axi_mem_slave
    import ysyx_22040750_axi_mem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [31:0]       I_mem_araddr,
    input  logic              I_mem_arvalid,
    input  logic [7:0]        I_mem_arlen,
    input  logic [2:0]        I_mem_arsize,
    output logic              O_mem_arready,
    output logic [BEAT_W-1:0] O_mem_rdata,
    output logic [RESP_W-1:0] O_mem_rresp,
    output logic              O_mem_rvalid,
    output logic              O_mem_rlast,
    input  logic              I_mem_rready,
    input  logic [31:0]       I_mem_awaddr,
    input  logic              I_mem_awvalid,
    input  logic [7:0]        I_mem_awlen,
    input  logic [2:0]        I_mem_awsize,
    output logic              O_mem_awready,
    input  logic [BEAT_W-1:0] I_mem_wdata,
    input  logic [STRB_W-1:0] I_mem_wstrb,
    input  logic              I_mem_wvalid,
    input  logic              I_mem_wlast,
    output logic              O_mem_wready,
    output logic [RESP_W-1:0] O_mem_bresp,
    output logic              O_mem_bvalid,
    input  logic              I_mem_bready
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned LAT_W     = $clog2(RD_LATENCY + 1) + 1;
    localparam int unsigned WAIT_LAST = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 3;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH_WORDS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic              err_q, err_d;
    logic [RESP_W-1:0] bresp_q, bresp_d;

    logic              mem_we;
    logic [BEAT_W-1:0] mem_rdata;
    logic [IDX_W-1:0]  idx_next;
    logic              last_beat;
    wbeat_t            wbeat;
    logic              unused_size;

    assign unused_size = ^{I_mem_arsize, I_mem_awsize};

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ({1'b0, off} >= SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    // Wrap explicitly so non-power-of-two depths also roll over to word 0.
    assign idx_next  = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    assign last_beat = (beat_q == len_q);
    assign wbeat     = '{data: I_mem_wdata, strb: I_mem_wstrb};

    ysyx_22040750_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem_array (
        .clk     (I_clk),
        .we      (mem_we),
        .waddr   (idx_q),
        .wbeat   (wbeat),
        .raddr   (idx_q),
        .rdata_c (mem_rdata)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            bresp_q <= bresp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        err_d   = err_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;

        O_mem_arready = 1'b0;
        O_mem_awready = 1'b0;
        O_mem_rvalid  = 1'b0;
        O_mem_rlast   = 1'b0;
        O_mem_rdata   = '0;
        O_mem_rresp   = RESP_OKAY;
        O_mem_wready  = 1'b0;
        O_mem_bvalid  = 1'b0;
        O_mem_bresp   = RESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                O_mem_arready = 1'b1;
                O_mem_awready = ~I_mem_arvalid;
                if (I_mem_arvalid) begin
                    idx_d   = addr_idx(I_mem_araddr);
                    len_d   = I_mem_arlen;
                    err_d   = addr_err(I_mem_araddr);
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = (RD_LATENCY > 1) ? ST_RD_WAIT : ST_RD_DATA;
                end else if (I_mem_awvalid) begin
                    idx_d   = addr_idx(I_mem_awaddr);
                    len_d   = I_mem_awlen;
                    err_d   = addr_err(I_mem_awaddr);
                    beat_d  = '0;
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == LAT_W'(WAIT_LAST)) begin
                    state_d = ST_RD_DATA;
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end
            ST_RD_DATA: begin
                O_mem_rvalid = 1'b1;
                O_mem_rlast  = last_beat;
                O_mem_rdata  = err_q ? '0 : mem_rdata;
                O_mem_rresp  = resp_of(err_q);
                if (I_mem_rready) begin
                    idx_d  = idx_next;
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR_DATA: begin
                O_mem_wready = 1'b1;
                if (I_mem_wvalid) begin
                    mem_we = ~err_q;
                    idx_d  = idx_next;
                    beat_d = beat_q + 8'd1;
                    // Burst closes on either wlast or the announced length; disagreement is an error.
                    if (I_mem_wlast || last_beat) begin
                        bresp_d = resp_of(err_q || (I_mem_wlast != last_beat));
                        state_d = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                O_mem_bvalid = 1'b1;
                O_mem_bresp  = bresp_q;
                if (I_mem_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
